// File: rtl/fetch_stage.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_stage : IF stage, single-outstanding imem fetch into the IF/ID register.
//               Optional macro FETCH_HALT_EN stops fetching after an ebreak.  Rev 1.0
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int              PC_W     = 9,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_ready_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               if_id_valid_o,
   output logic [PC_W-1:0]    if_id_pc_o,
   output logic [INSTR_W-1:0] if_id_instr_o,
   output logic               halted_o
);
   localparam logic [INSTR_W-1:0] C_NOP    = INSTR_W'(32'h0000_0013);
`ifdef FETCH_HALT_EN
   localparam logic [INSTR_W-1:0] C_EBREAK = INSTR_W'(32'h0010_0073);
`endif

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] skid_q, skid_d;
   logic               drop_q, drop_d;
   logic               valid_q, valid_d;
   logic [PC_W-1:0]    id_pc_q, id_pc_d;
   logic [INSTR_W-1:0] id_instr_q, id_instr_d;
`ifdef FETCH_HALT_EN
   logic               halted_q, halted_d;
`endif

   logic               take_rsp;
   logic               pending_drop;
   logic               load_en;
   logic [INSTR_W-1:0] load_instr;

   // A response present in the same cycle as a flush from WAIT is the one we
   // were owed, so nothing further is left to drop in that case.
   assign take_rsp     = (state_q == S_WAIT) && imem_rvalid_i && !drop_q;
   assign pending_drop = ((state_q == S_WAIT) && !take_rsp) || (drop_q && !imem_rvalid_i);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      skid_d     = skid_q;
      drop_d     = drop_q;
      valid_d    = valid_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
`ifdef FETCH_HALT_EN
      halted_d   = halted_q;
`endif
      load_en    = 1'b0;
      load_instr = skid_q;

      if (redirect_i) begin
         state_d    = S_REQ;
         pc_d       = redirect_pc_i;
         skid_d     = '0;
         // A request accepted in this very cycle will still answer later.
         drop_d     = pending_drop || ((state_q == S_REQ) && imem_ready_i);
         valid_d    = 1'b0;
         id_instr_d = C_NOP;
`ifdef FETCH_HALT_EN
         halted_d   = 1'b0;
`endif
      end else begin
         if (imem_rvalid_i && drop_q) begin
            drop_d = 1'b0;
         end
         case (state_q)
            S_REQ: begin
               if (imem_ready_i) begin
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (take_rsp) begin
                  if (stall_i) begin
                     skid_d  = imem_rdata_i;
                     state_d = S_HOLD;
                  end else begin
                     load_en    = 1'b1;
                     load_instr = imem_rdata_i;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  load_en    = 1'b1;
                  load_instr = skid_q;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase

         if (load_en) begin
            valid_d    = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = load_instr;
            pc_d       = pc_q + PC_W'(4);
            state_d    = S_REQ;
`ifdef FETCH_HALT_EN
            if (load_instr == C_EBREAK) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end
`endif
         end else if (!stall_i) begin
            valid_d    = 1'b0;
            id_instr_d = C_NOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         skid_q     <= '0;
         drop_q     <= pending_drop;
         valid_q    <= 1'b0;
         id_pc_q    <= '0;
         id_instr_q <= C_NOP;
`ifdef FETCH_HALT_EN
         halted_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         skid_q     <= skid_d;
         drop_q     <= drop_d;
         valid_q    <= valid_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
`ifdef FETCH_HALT_EN
         halted_q   <= halted_d;
`endif
      end
   end

   assign imem_req_o    = (state_q == S_REQ) && !reset;
   assign imem_addr_o   = pc_q;
   assign if_id_valid_o = valid_q;
   assign if_id_pc_o    = id_pc_q;
   assign if_id_instr_o = id_instr_q;
`ifdef FETCH_HALT_EN
   assign halted_o      = halted_q;
`else
   assign halted_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: directed scenarios plus randomized stimulus checked against a
// transaction-level fetch model and an in-order, variable-latency memory.
module tb_fetch_stage;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [8:0]  redirect_pc_i = '0;
   logic        imem_req_o;
   logic [8:0]  imem_addr_o;
   logic        imem_ready_i = 1'b1;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        if_id_valid_o;
   logic [8:0]  if_id_pc_o;
   logic [31:0] if_id_instr_o;
   logic        halted_o;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.PC_W(9), .INSTR_W(32), .RESET_PC(9'h000)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
      .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   // ---------------- instruction memory: in order, latency 'lat' ----------------
   logic [31:0] mem [128];
   int lat = 1;
   int cyc = 0;
   int unsigned req_count = 0;
   typedef struct { int due; logic [31:0] data; } rsp_t;
   rsp_t rq[$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (imem_req_o && imem_ready_i) begin
         req_count = req_count + 1;
         rq.push_back('{cyc + lat - 1, mem[imem_addr_o[8:2]]});
      end
      imem_rvalid_i <= 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
         imem_rvalid_i <= 1'b1;
         imem_rdata_i  <= rq[0].data;
         void'(rq.pop_front());
      end
   end

   // ---------------- reference model (transaction level) ----------------
   logic [8:0]  m_pc = '0;
   bit          m_want = 0;      // a useful response is owed to us
   bit          m_have = 0;      // an instruction is parked waiting for unstall
   logic [31:0] m_skid = '0;
   int          m_drop = 0;      // stale responses still to be discarded
   bit          m_halt = 0;
   logic        e_valid = 1'b0;
   logic [8:0]  e_pc = '0;
   logic [31:0] e_instr = NOP;

   always @(posedge clk) begin : model
      bit acc, use_rsp, ld;
      logic [31:0] ld_data;
      acc     = !reset && !m_want && !m_have && !m_halt && imem_ready_i;
      use_rsp = imem_rvalid_i && (m_drop == 0) && m_want;
      ld      = 0;
      ld_data = '0;
      if (imem_rvalid_i && m_drop > 0) m_drop = m_drop - 1;
      if (reset || redirect_i) begin
         if (m_want && !use_rsp) m_drop = m_drop + 1;
         if (acc) m_drop = m_drop + 1;
         m_want = 0; m_have = 0; m_halt = 0;
         m_pc    = reset ? 9'h000 : redirect_pc_i;
         e_valid = 1'b0;
         e_instr = NOP;
         if (reset) e_pc = '0;
      end else begin
         if (m_want) begin
            if (use_rsp) begin
               m_want = 0;
               if (stall_i) begin m_have = 1; m_skid = imem_rdata_i; end
               else begin ld = 1; ld_data = imem_rdata_i; end
            end
         end else if (m_have) begin
            if (!stall_i) begin ld = 1; ld_data = m_skid; m_have = 0; end
         end else if (acc) begin
            m_want = 1;
         end
         if (ld) begin
            e_valid = 1'b1; e_pc = m_pc; e_instr = ld_data;
            m_pc = m_pc + 9'd4;
`ifdef FETCH_HALT_EN
            if (ld_data == EBREAK) m_halt = 1;
`endif
         end else if (!stall_i) begin
            e_valid = 1'b0; e_instr = NOP;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_plan_mem();
      for (int i = 0; i < 128; i++) mem[i] = 32'h100 + 32'(i * 4);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b1; lat = 1;
      repeat (3) step();
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
      checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid_o); end
      checks++; if (if_id_pc_o !== 9'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", if_id_pc_o); end
      checks++; if (if_id_instr_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_id_instr_o, NOP); end
      checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted_o); end
   endtask

   task automatic test_stream();
      logic [8:0] pc_exp;
      reset = 1'b0;
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 9'h000) begin
         errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=000", imem_req_o, imem_addr_o);
      end
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k % 2 == 0) begin
            pc_exp = 9'((k / 2 - 1) * 4);
            checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== pc_exp || if_id_instr_o !== 32'h100 + 32'(pc_exp)) begin
               errors++; $display("FAIL stream_load k=%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                                  k, if_id_valid_o, if_id_pc_o, if_id_instr_o, pc_exp, 32'h100 + 32'(pc_exp));
            end
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 9'((k / 2) * 4)) begin
               errors++; $display("FAIL stream_req k=%0d: got req=%b addr=%h expected req=1 addr=%h",
                                  k, imem_req_o, imem_addr_o, 9'((k / 2) * 4));
            end
         end else begin
            pc_exp = (k == 1) ? 9'h000 : 9'(((k - 3) / 2) * 4);
            checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== pc_exp) begin
               errors++; $display("FAIL stream_bubble k=%0d: got v=%b pc=%h i=%h expected v=0 pc=%h i=%h",
                                  k, if_id_valid_o, if_id_pc_o, if_id_instr_o, pc_exp, NOP);
            end
         end
      end
   endtask

   task automatic test_stall_skid();
      int unsigned rc0;
      step();                         // request for 0x018 accepted
      rc0 = req_count;
      stall_i = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         checks++; if (if_id_valid_o !== 1'b0 || if_id_pc_o !== 9'h014 || if_id_instr_o !== NOP || imem_req_o !== 1'b0) begin
            errors++; $display("FAIL stall_freeze s=%0d: got v=%b pc=%h i=%h req=%b expected v=0 pc=014 i=%h req=0",
                               s, if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_req_o, NOP);
         end
      end
      stall_i = 1'b0;
      step();
      checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 9'h018 || if_id_instr_o !== 32'h118) begin
         errors++; $display("FAIL stall_release: got v=%b pc=%h i=%h expected v=1 pc=018 i=00000118",
                            if_id_valid_o, if_id_pc_o, if_id_instr_o);
      end
      checks++; if (req_count !== rc0 || imem_addr_o !== 9'h01c) begin
         errors++; $display("FAIL stall_no_refetch: got reqs=%0d addr=%h expected reqs=%0d addr=01c", req_count, imem_addr_o, rc0);
      end
   endtask

   task automatic test_redirect_drop();
      bit seen = 0;
      lat = 4;                        // response for 0x01c arrives late
      step();
      redirect_i = 1'b1; redirect_pc_i = 9'h040; lat = 1;
      step();
      redirect_i = 1'b0;
      checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== 9'h018) begin
         errors++; $display("FAIL redir_bubble: got v=%b pc=%h i=%h expected v=0 pc=018 i=%h",
                            if_id_valid_o, if_id_pc_o, if_id_instr_o, NOP);
      end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 9'h040) begin
         errors++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=040", imem_req_o, imem_addr_o);
      end
      for (int t = 0; t < 12 && !seen; t++) begin
         step();
         if (if_id_valid_o === 1'b1) seen = 1;
      end
      checks++; if (!seen || if_id_pc_o !== 9'h040 || if_id_instr_o !== 32'h140) begin
         errors++; $display("FAIL redir_first_valid: got seen=%b pc=%h i=%h expected seen=1 pc=040 i=00000140",
                            seen, if_id_pc_o, if_id_instr_o);
      end
   endtask

   task automatic test_wrap();
      bit seen = 0;
      redirect_i = 1'b1; redirect_pc_i = 9'h1fc;
      step();
      redirect_i = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
         step();
         if (if_id_valid_o === 1'b1) seen = 1;
      end
      checks++; if (!seen || if_id_pc_o !== 9'h1fc || if_id_instr_o !== 32'h2fc) begin
         errors++; $display("FAIL wrap_load: got seen=%b pc=%h i=%h expected seen=1 pc=1fc i=000002fc",
                            seen, if_id_pc_o, if_id_instr_o);
      end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 9'h000) begin
         errors++; $display("FAIL wrap_next_addr: got req=%b addr=%h expected req=1 addr=000", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_ready_hold();
      int unsigned rc0;
      imem_ready_i = 1'b0;
      rc0 = req_count;
      for (int s = 0; s < 3; s++) begin
         step();
         checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 9'h000) begin
            errors++; $display("FAIL ready_hold s=%0d: got req=%b addr=%h expected req=1 addr=000", s, imem_req_o, imem_addr_o);
         end
      end
      imem_ready_i = 1'b1;
      step();
      checks++; if (imem_req_o !== 1'b0 || req_count !== rc0 + 1) begin
         errors++; $display("FAIL ready_accept: got req=%b reqs=%0d expected req=0 reqs=%0d", imem_req_o, req_count, rc0 + 1);
      end
      step();
      checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 9'h000 || if_id_instr_o !== 32'h100) begin
         errors++; $display("FAIL ready_load: got v=%b pc=%h i=%h expected v=1 pc=000 i=00000100",
                            if_id_valid_o, if_id_pc_o, if_id_instr_o);
      end
   endtask

`ifdef FETCH_HALT_EN
   task automatic test_halt();
      bit seen = 0;
      int unsigned rc0;
      mem[2] = EBREAK;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         step();
         if (if_id_valid_o === 1'b1 && if_id_pc_o === 9'h008) seen = 1;
      end
      checks++; if (!seen || if_id_instr_o !== EBREAK || halted_o !== 1'b1) begin
         errors++; $display("FAIL halt_enter: got seen=%b i=%h halted=%b expected seen=1 i=%h halted=1",
                            seen, if_id_instr_o, halted_o, EBREAK);
      end
      rc0 = req_count;
      for (int s = 0; s < 10; s++) begin
         step();
         checks++; if (imem_req_o !== 1'b0 || halted_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
            errors++; $display("FAIL halt_idle s=%0d: got req=%b halted=%b v=%b expected req=0 halted=1 v=0",
                               s, imem_req_o, halted_o, if_id_valid_o);
         end
      end
      checks++; if (req_count !== rc0) begin errors++; $display("FAIL halt_reqs: got %0d expected %0d", req_count, rc0); end
      redirect_i = 1'b1; redirect_pc_i = 9'h020;
      step();
      redirect_i = 1'b0;
      checks++; if (halted_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 9'h020) begin
         errors++; $display("FAIL halt_exit: got halted=%b req=%b addr=%h expected halted=0 req=1 addr=020",
                            halted_o, imem_req_o, imem_addr_o);
      end
      mem[2] = 32'h108;
   endtask
`endif

   task automatic test_random();
      int gap = 0;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      stall_i = 1'b0; redirect_i = 1'b0; imem_ready_i = 1'b1; lat = 1;
      reset = 1'b1;
      repeat (2) step();
      for (int i = 0; i < 800; i++) begin
         reset        = 1'b0;
         redirect_i   = 1'b0;
         stall_i      = ($urandom_range(0, 99) < 30);
         imem_ready_i = ($urandom_range(0, 99) < 70);
         lat          = int'($urandom_range(1, 2));
         if (gap >= 4 && $urandom_range(0, 99) < 5) begin
            redirect_i = 1'b1; redirect_pc_i = 9'($urandom); gap = 0;
         end else if (gap >= 4 && $urandom_range(0, 199) == 0) begin
            reset = 1'b1; gap = 0;
         end
         gap++;
         step();
         checks++; if (if_id_valid_o !== e_valid || if_id_pc_o !== e_pc || if_id_instr_o !== e_instr) begin
            errors++; $display("FAIL rnd_ifid i=%0d: got v=%b pc=%h i=%h expected v=%b pc=%h i=%h",
                               i, if_id_valid_o, if_id_pc_o, if_id_instr_o, e_valid, e_pc, e_instr);
         end
         checks++; if (imem_req_o !== (!reset && !m_want && !m_have && !m_halt)) begin
            errors++; $display("FAIL rnd_req i=%0d: got %b expected %b", i, imem_req_o, !reset && !m_want && !m_have && !m_halt);
         end
         if (imem_req_o === 1'b1) begin
            checks++; if (imem_addr_o !== m_pc) begin
               errors++; $display("FAIL rnd_addr i=%0d: got %h expected %h", i, imem_addr_o, m_pc);
            end
         end
         checks++; if (halted_o !== m_halt) begin
            errors++; $display("FAIL rnd_halted i=%0d: got %b expected %b", i, halted_o, m_halt);
         end
      end
   endtask

   initial begin
      load_plan_mem();
      test_reset();
      test_stream();
      test_stall_skid();
      test_redirect_drop();
      test_wrap();
      test_ready_hold();
`ifdef FETCH_HALT_EN
      test_halt();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
